// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the rasterizer and seq_multiplier.
// The master drives the operands and start; the slave returns the product and valid.
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 11
);
    logic signed [WIDTH-1:0]   a;
    logic signed [WIDTH-1:0]   b;
    logic                      start;
    logic signed [2*WIDTH-1:0] c;
    logic                      valid;

    modport master (output a, output b, output start, input c, input valid);
    modport slave  (input a, input b, input start, output c, output valid);
endinterface

// File: rtl/seq_multiplier.sv
// Iterative signed shift-add multiplier on sign/magnitude operands.
// Define MULT_RADIX4_EN to retire two multiplier bits per clock instead of one.
module seq_multiplier #(
    parameter int unsigned WIDTH = 11
) (
    input logic             clock,
    input logic             reset,
    seq_multiplier_if.slave mul_io
);

`ifdef MULT_RADIX4_EN
    localparam int unsigned Iters = (WIDTH + 1) / 2;
`else
    localparam int unsigned Iters = WIDTH;
`endif
    localparam int unsigned CntW = $clog2(Iters + 1);
    localparam int unsigned PW   = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [PW-1:0]          acc_q, acc_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   sign_q, sign_d;
    logic                   cooldown_q, cooldown_d;
    logic signed [PW-1:0]   c_q, c_d;
    logic                   valid_q, valid_d;

    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [PW-1:0]          addend;
    logic [PW-1:0]          mcand_shift;
    logic [WIDTH-1:0]       mplier_shift;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        mag_a = mul_io.a[WIDTH-1] ? (~mul_io.a + WIDTH'(1)) : mul_io.a;
        mag_b = mul_io.b[WIDTH-1] ? (~mul_io.b + WIDTH'(1)) : mul_io.b;
    end

`ifdef MULT_RADIX4_EN
    always_comb begin
        addend = '0;
        unique case (mplier_q[1:0])
            2'd0: addend = '0;
            2'd1: addend = mcand_q;
            2'd2: addend = mcand_q << 1;
            2'd3: addend = mcand_q + (mcand_q << 1);
        endcase
        mcand_shift  = mcand_q << 2;
        mplier_shift = mplier_q >> 2;
    end
`else
    always_comb begin
        addend       = mplier_q[0] ? mcand_q : '0;
        mcand_shift  = mcand_q << 1;
        mplier_shift = mplier_q >> 1;
    end
`endif

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        cooldown_d = cooldown_q;
        c_d        = c_q;
        valid_d    = 1'b0;

        case (state_q)
            StIdle: begin
                // First idle cycle after a result ignores start so the requester can reload.
                if (cooldown_q) begin
                    cooldown_d = 1'b0;
                end else if (mul_io.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    sign_d   = mul_io.a[WIDTH-1] ^ mul_io.b[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                acc_d    = acc_q + addend;
                mcand_d  = mcand_shift;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(Iters - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                c_d        = sign_q ? -acc_q : acc_q;
                valid_d    = 1'b1;
                cooldown_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            cooldown_q <= 1'b0;
            c_q        <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            cooldown_q <= cooldown_d;
            c_q        <= c_d;
            valid_q    <= valid_d;
        end
    end

    assign mul_io.c     = c_q;
    assign mul_io.valid = valid_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a cycle-level product/timing model checked every cycle,
// directed cases with literal products, then a random operand/start sweep.
module tb_seq_multiplier;

    localparam int unsigned W = 11;
`ifdef MULT_RADIX4_EN
    localparam int Lat = (W + 1) / 2 + 1;
`else
    localparam int Lat = W + 1;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    seq_multiplier_if #(.WIDTH(W)) mif ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .mul_io (mif)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request yields a*b Lat edges later; the next acceptance is
    // allowed no earlier than Lat+2 edges after the previous one.
    int     cyc     = 0;
    int     due     = -1;
    int     next_ok = 0;
    longint pend    = 0;
    longint m_c     = 0;
    bit     m_valid = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0;
            m_c     = 0;
            due     = -1;
            next_ok = 0;
        end else begin
            cyc++;
            m_valid = (cyc == due);
            if (m_valid) m_c = pend;
            if (mif.start && cyc >= next_ok) begin
                pend    = longint'(mif.a) * longint'(mif.b);
                due     = cyc + Lat;
                next_ok = cyc + Lat + 2;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("valid", longint'(mif.valid), longint'(m_valid));
            check("c", longint'(mif.c), m_c);
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mif.valid && n < 60);
        if (!mif.valid) check("valid_timeout", longint'(mif.valid), 1);
    endtask

    task automatic op(input string name, input int ta, input int tb, input longint exp);
        int n;
        @(negedge clock);
        mif.a     = W'(ta);
        mif.b     = W'(tb);
        mif.start = 1'b1;
        @(negedge clock);
        mif.start = 1'b0;
        wait_valid(n);
        check({name, "_lat"}, n + 1, Lat + 1);
        check({name, "_c"}, longint'(mif.c), exp);
        check({name, "_model"}, m_c, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int     n, seen;
        time    t1, t2;
        int     corners [5] = '{-1024, 1023, 0, -1, 1};

        mif.a     = '0;
        mif.b     = '0;
        mif.start = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_c", longint'(mif.c), 0);
        check("rst_valid", longint'(mif.valid), 0);
        reset = 1'b0;

        op("t1", 3, -5, -15);
        @(negedge clock);
        check("t1_hold_c", longint'(mif.c), -15);
        check("t1_hold_valid", longint'(mif.valid), 0);

        op("t2a", -1024, -1024, 1048576);
        op("t2b", -1024, 1023, -1047552);
        op("t2c", 0, 777, 0);

        // Start held high; reload operands during the cooldown cycle.
        @(negedge clock);
        mif.a     = W'(7);
        mif.b     = W'(6);
        mif.start = 1'b1;
        wait_valid(n);
        t1 = $time;
        check("t3_c0", longint'(mif.c), 42);
        @(negedge clock);
        mif.a = W'(-2);
        mif.b = W'(9);
        wait_valid(n);
        t2 = $time;
        mif.start = 1'b0;
        check("t3_c1", longint'(mif.c), -18);
        check("t3_model", m_c, -18);
        check("t3_period", longint'((t2 - t1) / 10), Lat + 2);

        // Operand and start changes while busy are ignored.
        @(negedge clock);
        mif.a     = W'(12);
        mif.b     = W'(-12);
        mif.start = 1'b1;
        @(negedge clock);
        mif.start = 1'b0;
        repeat (2) @(negedge clock);
        mif.a     = W'(100);
        mif.b     = W'(100);
        mif.start = 1'b1;
        @(negedge clock);
        mif.start = 1'b0;
        wait_valid(n);
        check("t4_c", longint'(mif.c), -144);
        check("t4_model", m_c, -144);

        // Reset in the middle of an operation.
        repeat (2) @(negedge clock);
        mif.a     = W'(50);
        mif.b     = W'(-3);
        mif.start = 1'b1;
        @(negedge clock);
        mif.start = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_c", longint'(mif.c), 0);
        check("t5_rst_valid", longint'(mif.valid), 0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        seen = 0;
        repeat (Lat + 4) begin
            @(negedge clock);
            if (mif.valid) seen++;
        end
        check("t5_no_pulse", seen, 0);
        op("t5_after", -7, 9, -63);

        // Random sweep; the per-cycle compare carries all the checking here.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clock);
            if ($urandom_range(7) == 0) begin
                mif.a = W'(corners[$urandom_range(4)]);
                mif.b = W'(corners[$urandom_range(4)]);
            end else begin
                mif.a = W'($urandom);
                mif.b = W'($urandom);
            end
            mif.start = ($urandom_range(3) != 0);
        end
        mif.start = 1'b0;
        repeat (Lat + 4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
